iram_code_loader: RTL

Loads program code into on-chip instruction memory from a byte stream, such as the debug/UART boot path. It packs big-endian bytes into 32-bit instruction words and writes each word to the upper and lower 16-bit instruction-RAM halves on their shared write port. It sits directly upstream of the instruction-RAM halves and drives their `we`, write address and `data_in`. It has optional checksum verification.

---
 rtl/iram_loader_pkg.sv | 22 ++
 rtl/iram_word_packer.sv | 35 +++
 rtl/iram_code_loader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/iram_loader_pkg.sv
// iram_loader_pkg: shared types and sizing for the instruction-RAM code loader.
// Holds the FSM state enum and the address/count widths derived from the PC width.
package iram_loader_pkg;

    localparam int PC_BITWIDTH = 12;
    localparam int ON_CHIP_CODE_RAM_SIZE_IN_BYTES = 1024;

    localparam int IRAM_WORDS = ON_CHIP_CODE_RAM_SIZE_IN_BYTES / 4;
    localparam int ADDR_W = PC_BITWIDTH - 2;
    localparam int COUNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
`ifdef IRAM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } loader_state_t;

endpackage

// File: rtl/iram_word_packer.sv
// iram_word_packer: gathers four big-endian bytes into one 32-bit word.
// Ports: clear (restart at byte 0), accept/byte_in (stream), word, word_complete.
module iram_word_packer
    import iram_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [1:0]  idx_q;
    logic [23:0] shreg_q;

    // The byte being accepted is already part of the word, so the top can
    // capture a full word on the same edge that takes byte 3.
    assign word = {shreg_q, byte_in};
    assign word_complete = accept && !clear && (idx_q == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= 2'd0;
            shreg_q <= 24'd0;
        end else if (clear) begin
            idx_q <= 2'd0;
        end else if (accept) begin
            idx_q   <= idx_q + 2'd1;
            shreg_q <= word[23:0];
        end
    end

endmodule

// File: rtl/iram_code_loader.sv
// iram_code_loader: loads code words from a byte stream into the split
// hi/lo 16-bit instruction RAM. Ports: start/start_addr/word_count/abort
// (session control), byte_in/byte_valid/byte_ready (stream), iram_we/
// iram_addr/iram_data_hi/iram_data_lo (RAM write port), busy/done/error.
// Optional checksum byte after the code: IRAM_LOADER_CHECKSUM_EN.
module iram_code_loader
    import iram_loader_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_W,
    parameter int RAM_WORDS = IRAM_WORDS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] start_addr,
    input  logic [ADDR_BITS:0]   word_count,
    input  logic                 abort,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 iram_we,
    output logic [ADDR_BITS-1:0] iram_addr,
    output logic [15:0]          iram_data_hi,
    output logic [15:0]          iram_data_lo,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    loader_state_t state, state_n;

    logic [ADDR_BITS-1:0] addr_q;
    logic [ADDR_BITS:0]   remain_q;
    logic [ADDR_BITS+1:0] end_addr;
    logic [31:0]          word;
    logic range_bad, go, kill, accept;
    logic word_complete, last_word, ck_fail;

    assign go = (state == S_IDLE) && start;
    assign kill = (state != S_IDLE) && abort;
    assign accept = byte_valid && byte_ready;

    // Two extra bits so start_addr + word_count cannot overflow.
    assign end_addr = {2'b00, start_addr} + {1'b0, word_count};
    assign range_bad = end_addr > (ADDR_BITS+2)'(RAM_WORDS);
    assign last_word = remain_q == (ADDR_BITS+1)'(1);

`ifdef IRAM_LOADER_CHECKSUM_EN
    localparam loader_state_t S_TAIL = S_CHECK;

    logic [7:0] sum_q;
    logic [7:0] ck_total;

    assign ck_total = sum_q + byte_in;
    assign ck_fail = (state == S_CHECK) && accept && !abort
                     && (ck_total != 8'h00);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 8'h00;
        end else if (go) begin
            sum_q <= 8'h00;
        end else if (accept && (state == S_COLLECT)) begin
            sum_q <= sum_q + byte_in;
        end
    end

    always_comb begin
        byte_ready = 1'b0;
        if ((state == S_COLLECT) || (state == S_CHECK)) begin
            byte_ready = 1'b1;
        end
    end
`else
    localparam loader_state_t S_TAIL = S_DONE;

    assign ck_fail = 1'b0;

    always_comb begin
        byte_ready = 1'b0;
        if (state == S_COLLECT) begin
            byte_ready = 1'b1;
        end
    end
`endif

    iram_word_packer u_packer (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (go || kill),
        .accept        (accept && (state == S_COLLECT)),
        .byte_in       (byte_in),
        .word          (word),
        .word_complete (word_complete)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        state_n = S_TAIL;
                    end else if (!range_bad) begin
                        state_n = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (word_complete) begin
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                state_n = last_word ? S_TAIL : S_COLLECT;
            end
`ifdef IRAM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    state_n = ck_fail ? S_IDLE : S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (kill) begin
            state_n = S_IDLE;
        end
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe (iram_we during WRITE, done during DONE).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            remain_q     <= '0;
            iram_we      <= 1'b0;
            iram_addr    <= '0;
            iram_data_hi <= 16'h0000;
            iram_data_lo <= 16'h0000;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state   <= state_n;
            iram_we <= (state_n == S_WRITE);
            busy    <= (state_n != S_IDLE);
            done    <= (state_n == S_DONE);
            error   <= (go && (word_count != '0) && range_bad) || ck_fail;
            if (go) begin
                addr_q   <= start_addr;
                remain_q <= word_count;
            end else if (state == S_WRITE) begin
                addr_q   <= addr_q + ADDR_BITS'(1);
                remain_q <= remain_q - (ADDR_BITS+1)'(1);
            end
            if (state_n == S_WRITE) begin
                iram_addr    <= addr_q;
                iram_data_hi <= word[31:16];
                iram_data_lo <= word[15:0];
            end
        end
    end

endmodule
